// File: rtl/id_pipe.sv
// rtl/id_pipe.sv - MIPS decode stage: decode, EX/MEM forwarding, load-use bubble, registered ID/EX with valid/ready
module id_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [31:0]       pc_i,
    input  logic [31:0]       inst_i,
    input  logic              flush_i,
    output logic              reg1_read_o,
    output logic              reg2_read_o,
    output logic [REG_AW-1:0] reg1_addr_o,
    output logic [REG_AW-1:0] reg2_addr_o,
    input  logic [DATA_W-1:0] reg1_data_i,
    input  logic [DATA_W-1:0] reg2_data_i,
    input  logic              ex_wreg_i,
    input  logic [REG_AW-1:0] ex_wd_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    input  logic              mem_wreg_i,
    input  logic [REG_AW-1:0] mem_wd_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic              out_valid_o,
    input  logic              ex_ready_i,
    output logic [31:0]       pc_o,
    output logic [7:0]        aluop_o,
    output logic [2:0]        alusel_o,
    output logic [DATA_W-1:0] reg1_o,
    output logic [DATA_W-1:0] reg2_o,
    output logic [REG_AW-1:0] wd_o,
    output logic              wreg_o,
    output logic              is_load_o,
    output logic              inst_invalid_o,
    output logic [CNT_W-1:0]  invalid_cnt_o
);

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [2:0] SEL_LOGIC  = 3'b001;
    localparam logic [2:0] SEL_LOAD   = 3'b111;

    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [4:0]        shamt;
    logic [7:0]        dec_aluop;
    logic [2:0]        dec_alusel;
    logic [DATA_W-1:0] dec_imm;
    logic [REG_AW-1:0] dec_wd;
    logic              dec_wreg;
    logic              dec_load;
    logic              dec_invalid;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic              hazard1;
    logic              hazard2;
    logic              stall;
    logic              advance;
    logic              load;

    assign opcode = inst_i[31:26];
    assign shamt  = inst_i[10:6];
    assign funct  = inst_i[5:0];

    always_comb begin
        reg1_read_o = 1'b0;
        reg2_read_o = 1'b0;
        reg1_addr_o = REG_AW'(inst_i[25:21]);
        reg2_addr_o = REG_AW'(inst_i[20:16]);
        dec_aluop   = 8'h00;
        dec_alusel  = 3'b000;
        dec_imm     = '0;
        dec_wd      = REG_AW'(inst_i[20:16]);
        dec_wreg    = 1'b0;
        dec_load    = 1'b0;
        dec_invalid = 1'b0;
        case (opcode)
            OP_ORI, OP_ANDI, OP_XORI: begin
                dec_aluop   = (opcode == OP_ORI)  ? 8'b00100101 :
                              (opcode == OP_ANDI) ? 8'b00100100 : 8'b00100110;
                dec_alusel  = SEL_LOGIC;
                reg1_read_o = 1'b1;
                dec_imm     = DATA_W'(inst_i[15:0]);
                dec_wreg    = 1'b1;
            end
            OP_LUI: begin
                // LUI is an OR of $0 with the shifted immediate
                dec_aluop   = 8'b00100101;
                dec_alusel  = SEL_LOGIC;
                reg1_read_o = 1'b1;
                reg1_addr_o = '0;
                dec_imm     = DATA_W'({inst_i[15:0], 16'h0000});
                dec_wreg    = 1'b1;
            end
            OP_LW: begin
                dec_aluop   = 8'b11100011;
                dec_alusel  = SEL_LOAD;
                reg1_read_o = 1'b1;
                dec_imm     = DATA_W'($signed(inst_i[15:0]));
                dec_wreg    = 1'b1;
                dec_load    = 1'b1;
            end
            OP_SPECIAL: begin
                if (shamt == 5'd0 && funct[5:2] == 4'b1001) begin
                    dec_aluop   = {2'b00, funct};
                    dec_alusel  = SEL_LOGIC;
                    reg1_read_o = 1'b1;
                    reg2_read_o = 1'b1;
                    dec_wd      = REG_AW'(inst_i[15:11]);
                    dec_wreg    = 1'b1;
                end else begin
                    dec_invalid = 1'b1;
                end
            end
            default: dec_invalid = 1'b1;
        endcase
    end

    // EX is the younger producer, so it wins over MEM
    assign op1 = !reg1_read_o                                 ? '0          :
                 (reg1_addr_o == '0)                          ? '0          :
                 (ex_wreg_i  && ex_wd_i  == reg1_addr_o)      ? ex_wdata_i  :
                 (mem_wreg_i && mem_wd_i == reg1_addr_o)      ? mem_wdata_i : reg1_data_i;
    assign op2 = !reg2_read_o                                 ? dec_imm     :
                 (reg2_addr_o == '0)                          ? '0          :
                 (ex_wreg_i  && ex_wd_i  == reg2_addr_o)      ? ex_wdata_i  :
                 (mem_wreg_i && mem_wd_i == reg2_addr_o)      ? mem_wdata_i : reg2_data_i;

    assign hazard1 = reg1_read_o && (reg1_addr_o == wd_o);
    assign hazard2 = reg2_read_o && (reg2_addr_o == wd_o);
    assign stall   = out_valid_o && is_load_o && wreg_o && (wd_o != '0) && (hazard1 || hazard2);
    assign advance = !out_valid_o || ex_ready_i;
    assign in_ready_o = rst && (flush_i || (advance && !stall));
    assign load    = !flush_i && advance && !stall && in_valid_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_o    <= 1'b0;
            pc_o           <= '0;
            aluop_o        <= '0;
            alusel_o       <= '0;
            reg1_o         <= '0;
            reg2_o         <= '0;
            wd_o           <= '0;
            wreg_o         <= 1'b0;
            is_load_o      <= 1'b0;
            inst_invalid_o <= 1'b0;
            invalid_cnt_o  <= '0;
        end else begin
            if (flush_i) begin
                out_valid_o <= 1'b0;
            end else if (advance) begin
                out_valid_o <= load;
            end
            if (load) begin
                pc_o           <= pc_i;
                aluop_o        <= dec_aluop;
                alusel_o       <= dec_alusel;
                reg1_o         <= op1;
                reg2_o         <= op2;
                wd_o           <= dec_wd;
                wreg_o         <= dec_wreg;
                is_load_o      <= dec_load;
                inst_invalid_o <= dec_invalid;
                if (dec_invalid && !(&invalid_cnt_o)) begin
                    invalid_cnt_o <= invalid_cnt_o + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_id_pipe.sv
// tb/tb_id_pipe.sv - randomized and directed checks of id_pipe against a behavioural model
module tb_id_pipe;

    localparam int CW      = 2;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_i, flush_i, ex_ready_i;
    logic [31:0] pc_i, inst_i;
    logic        ex_wreg_i, mem_wreg_i;
    logic [4:0]  ex_wd_i, mem_wd_i;
    logic [31:0] ex_wdata_i, mem_wdata_i;
    logic [31:0] reg1_data_i, reg2_data_i;
    logic        in_ready_o, reg1_read_o, reg2_read_o, out_valid_o;
    logic [4:0]  reg1_addr_o, reg2_addr_o, wd_o;
    logic [31:0] pc_o, reg1_o, reg2_o;
    logic [7:0]  aluop_o;
    logic [2:0]  alusel_o;
    logic        wreg_o, is_load_o, inst_invalid_o;
    logic [CW-1:0] invalid_cnt_o;

    logic [31:0] rf [32];
    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        re1, re2;
        logic [4:0]  a1, a2, wd;
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] imm;
        logic        wreg, ld, inv;
    } dec_t;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] r1, r2;
        logic [4:0]  wd;
        logic        wreg, ld, inv;
    } idex_t;

    idex_t m;
    int    mcnt;

    always #5 clk = ~clk;

    assign reg1_data_i = rf[reg1_addr_o];
    assign reg2_data_i = rf[reg2_addr_o];

    id_pipe #(.DATA_W(32), .REG_AW(5), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .pc_i(pc_i), .inst_i(inst_i), .flush_i(flush_i),
        .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
        .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
        .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
        .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i),
        .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
        .out_valid_o(out_valid_o), .ex_ready_i(ex_ready_i),
        .pc_o(pc_o), .aluop_o(aluop_o), .alusel_o(alusel_o),
        .reg1_o(reg1_o), .reg2_o(reg2_o), .wd_o(wd_o), .wreg_o(wreg_o),
        .is_load_o(is_load_o), .inst_invalid_o(inst_invalid_o),
        .invalid_cnt_o(invalid_cnt_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Instruction semantics as listed for the MIPS subset
    function automatic dec_t decode(input logic [31:0] w);
        dec_t d = '0;
        logic [15:0] im = w[15:0];
        d.a1 = w[25:21];
        d.a2 = w[20:16];
        d.wd = w[20:16];
        case (w[31:26])
            6'h0D: begin d.re1 = 1; d.aluop = 8'h25; d.alusel = 3'd1; d.imm = {16'h0, im}; d.wreg = 1; end
            6'h0C: begin d.re1 = 1; d.aluop = 8'h24; d.alusel = 3'd1; d.imm = {16'h0, im}; d.wreg = 1; end
            6'h0E: begin d.re1 = 1; d.aluop = 8'h26; d.alusel = 3'd1; d.imm = {16'h0, im}; d.wreg = 1; end
            6'h0F: begin d.re1 = 1; d.a1 = 5'd0; d.aluop = 8'h25; d.alusel = 3'd1; d.imm = {im, 16'h0}; d.wreg = 1; end
            6'h23: begin d.re1 = 1; d.aluop = 8'hE3; d.alusel = 3'd7; d.imm = {{16{im[15]}}, im}; d.wreg = 1; d.ld = 1; end
            6'h00: begin
                if (w[10:6] == 5'd0 && w[5:0] inside {[6'h24:6'h27]}) begin
                    d.re1 = 1; d.re2 = 1; d.aluop = {2'b00, w[5:0]}; d.alusel = 3'd1;
                    d.wd = w[15:11]; d.wreg = 1;
                end else d.inv = 1;
            end
            default: d.inv = 1;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] operand(input logic re, input logic [4:0] a, input logic [31:0] off_val);
        if (!re) return off_val;
        if (a == 5'd0) return 32'h0;
        if (ex_wreg_i && ex_wd_i == a) return ex_wdata_i;
        if (mem_wreg_i && mem_wd_i == a) return mem_wdata_i;
        return rf[a];
    endfunction

    task automatic check_regs();
        chk("out_valid", out_valid_o, m.v);
        chk("invalid_cnt", invalid_cnt_o, mcnt);
        if (m.v) begin
            chk("pc", pc_o, m.pc);
            chk("aluop", aluop_o, m.aluop);
            chk("alusel", alusel_o, m.alusel);
            chk("reg1", reg1_o, m.r1);
            chk("wreg", wreg_o, m.wreg);
            chk("is_load", is_load_o, m.ld);
            chk("inst_invalid", inst_invalid_o, m.inv);
            if (!m.inv) chk("reg2", reg2_o, m.r2);
            if (m.wreg) chk("wd", wd_o, m.wd);
        end
    endtask

    // Entered at a falling edge with inputs already driven; returns at the next falling edge
    task automatic cycle();
        dec_t  d;
        idex_t nx;
        logic  adv, stl;
        int    ncnt;
        #1;
        d   = decode(inst_i);
        adv = !m.v || ex_ready_i;
        stl = m.v && m.ld && m.wreg && (m.wd != 0) &&
              ((d.re1 && d.a1 == m.wd) || (d.re2 && d.a2 == m.wd));
        chk("in_ready", in_ready_o, flush_i || (adv && !stl));
        chk("reg1_read", reg1_read_o, d.re1);
        chk("reg2_read", reg2_read_o, d.re2);
        chk("reg1_addr", reg1_addr_o, d.a1);
        chk("reg2_addr", reg2_addr_o, d.a2);
        nx   = m;
        ncnt = mcnt;
        if (flush_i) nx.v = 0;
        else if (!adv) nx = m;
        else if (stl) nx.v = 0;
        else if (in_valid_i) begin
            nx = '{v: 1'b1, pc: pc_i, aluop: d.aluop, alusel: d.alusel,
                   r1: operand(d.re1, d.a1, 32'h0), r2: operand(d.re2, d.a2, d.imm),
                   wd: d.wd, wreg: d.wreg, ld: d.ld, inv: d.inv};
            if (d.inv && ncnt < CNT_MAX) ncnt++;
        end else nx.v = 0;
        @(posedge clk);
        #1;
        m    = nx;
        mcnt = ncnt;
        check_regs();
        @(negedge clk);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_in_ready"}, in_ready_o, 1'b0);
        chk({tag, "_out_valid"}, out_valid_o, 1'b0);
        chk({tag, "_cnt"}, invalid_cnt_o, 0);
        chk({tag, "_regs"}, {pc_o, aluop_o, alusel_o, reg1_o, reg2_o, wd_o, wreg_o, is_load_o, inst_invalid_o}, 0);
        chk({tag, "_regs_hi"}, {reg1_o, reg2_o}, 64'h0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check_cleared("reset");
        m    = '0;
        mcnt = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic present(input logic [31:0] pc, input logic [31:0] w);
        in_valid_i = 1'b1;
        pc_i       = pc;
        inst_i     = w;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [4:0]  rs = 5'($urandom_range(0, 7));
        logic [4:0]  rt = 5'($urandom_range(0, 7));
        logic [4:0]  rd = 5'($urandom_range(0, 7));
        logic [15:0] im = 16'($urandom);
        logic [5:0]  fn = 6'(6'h24 + 6'($urandom_range(0, 3)));
        case ($urandom_range(0, 9))
            0: return {6'h0D, rs, rt, im};
            1: return {6'h0C, rs, rt, im};
            2: return {6'h0E, rs, rt, im};
            3: return {6'h0F, rs, rt, im};
            4, 5: return {6'h00, rs, rt, rd, 5'd0, fn};
            6, 7: return {6'h23, rs, rt, im};
            8: return $urandom;
            default: return {6'h00, rs, rt, rd, 5'($urandom_range(0, 31)), 6'($urandom_range(0, 63))};
        endcase
    endfunction

    task automatic rand_inputs();
        in_valid_i  = ($urandom_range(0, 9) < 8);
        flush_i     = ($urandom_range(0, 19) == 0);
        ex_ready_i  = ($urandom_range(0, 9) < 7);
        pc_i        = $urandom & 32'hFFFF_FFFC;
        inst_i      = rand_inst();
        ex_wreg_i   = 1'($urandom_range(0, 1));
        ex_wd_i     = 5'($urandom_range(0, 7));
        ex_wdata_i  = $urandom;
        mem_wreg_i  = 1'($urandom_range(0, 1));
        mem_wd_i    = 5'($urandom_range(0, 7));
        mem_wdata_i = $urandom;
        if ($urandom_range(0, 3) == 0) rf[$urandom_range(0, 31)] = $urandom;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        {in_valid_i, flush_i, ex_ready_i, pc_i, inst_i} = '0;
        {ex_wreg_i, ex_wd_i, ex_wdata_i, mem_wreg_i, mem_wd_i, mem_wdata_i} = '0;
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rf[1] = 32'h1;
        rf[2] = 32'h2222;
        m = '0;
        mcnt = 0;
        @(negedge clk);
        do_reset();

        // invalid opcodes and counter saturation at 2 bits
        ex_ready_i = 1'b1;
        present(32'h0, 32'hFC00_0000);
        repeat (3) cycle();
        chk("inv_flag", inst_invalid_o, 1'b1);
        chk("inv_wreg", wreg_o, 1'b0);
        chk("inv_cnt3", invalid_cnt_o, 3);
        repeat (2) cycle();
        chk("inv_cnt_sat", invalid_cnt_o, 3);

        // asynchronous reset in the middle of a cycle
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_cleared("async");
        m = '0;
        mcnt = 0;
        @(negedge clk);
        rst = 1'b1;

        // ORI with EX forwarding
        ex_wreg_i = 1'b1; ex_wd_i = 5'd1; ex_wdata_i = 32'h100;
        present(32'h100, 32'h3422_0F0F);
        cycle();
        chk("ori_reg1", reg1_o, 32'h100);
        chk("ori_reg2", reg2_o, 32'h0F0F);
        chk("ori_wd", wd_o, 5'd2);
        chk("ori_aluop", aluop_o, 8'h25);
        chk("ori_valid", out_valid_o, 1'b1);

        // forwarding priority: EX over MEM, then MEM on the other port, then $0
        ex_wd_i = 5'd1; ex_wdata_i = 32'hA;
        mem_wreg_i = 1'b1; mem_wd_i = 5'd1; mem_wdata_i = 32'hB;
        present(32'h104, 32'h0022_1825);
        cycle();
        chk("prio_reg1", reg1_o, 32'hA);
        chk("prio_reg2_rf", reg2_o, 32'h2222);
        mem_wd_i = 5'd2; mem_wdata_i = 32'hC;
        cycle();
        chk("prio_reg2_mem", reg2_o, 32'hC);
        ex_wd_i = 5'd0; mem_wd_i = 5'd0;
        present(32'h108, 32'h0002_1825);
        cycle();
        chk("zero_reg1", reg1_o, 32'h0);
        chk("zero_reg2", reg2_o, 32'h2222);

        // load-use: one bubble, then MEM forwarding
        ex_wreg_i = 1'b0; mem_wreg_i = 1'b0;
        present(32'h200, 32'h8C04_0004);
        cycle();
        present(32'h204, 32'h3085_00FF);
        #1 chk("lu_ready", in_ready_o, 1'b0);
        cycle();
        chk("lu_bubble", out_valid_o, 1'b0);
        mem_wreg_i = 1'b1; mem_wd_i = 5'd4; mem_wdata_i = 32'h4444;
        cycle();
        chk("lu_valid", out_valid_o, 1'b1);
        chk("lu_fwd", reg1_o, 32'h4444);
        chk("lu_pc", pc_o, 32'h204);

        // backpressure holds outputs
        mem_wreg_i = 1'b0;
        ex_ready_i = 1'b0;
        present(32'h208, 32'h3466_1234);
        for (int k = 0; k < 3; k++) begin
            #1 chk("bp_ready", in_ready_o, 1'b0);
            cycle();
            chk("bp_pc", pc_o, 32'h204);
            chk("bp_reg1", reg1_o, 32'h4444);
        end
        ex_ready_i = 1'b1;
        cycle();
        chk("bp_release_pc", pc_o, 32'h208);

        // flush beats a load-use stall
        present(32'h300, 32'h8C04_0004);
        cycle();
        present(32'h304, 32'h3085_00FF);
        flush_i = 1'b1;
        #1 chk("fl_ready", in_ready_o, 1'b1);
        cycle();
        chk("fl_valid", out_valid_o, 1'b0);
        present(32'h308, 32'hFC00_0000);
        cycle();
        chk("fl_cnt", invalid_cnt_o, 0);
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        cycle();

        for (int i = 0; i < 4000; i++) begin
            if (i % 300 == 299) do_reset();
            rand_inputs();
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_pipe.md
# id_pipe

Parametrised decode stage for the MIPS core. It replaces the purely combinational decoder with the following structure:

- Combinational decode of the IF/ID instruction.
- Operand forwarding from the EX and MEM stages.
- Load-use hazard detection with automatic bubble insertion.
- A registered ID/EX output with valid/ready flow control.

It sits between the IF/ID register and the EX stage, and connects directly to the regfile read ports.

## Interface
- DATA_W, 32: datapath width; must be ≥32.
- REG_AW, 5: register address width.
- CNT_W, 16: width of the invalid-instruction counter.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low: 0 clears all state immediately.
- in_valid_i  in  1  the IF/ID instruction is valid.
- in_ready_o  out  1  this block accepts the instruction this cycle.
- pc_i  in  32  instruction address.
- inst_i  in  32  instruction word.
- flush_i  in  1  discard the presented instruction and the ID/EX contents.
- reg1_read_o / reg2_read_o  out  1  regfile read enables (combinational).
- reg1_addr_o / reg2_addr_o  out  REG_AW  regfile read addresses, inst_i[25:21] / inst_i[20:16] (combinational).
- reg1_data_i / reg2_data_i  in  DATA_W  regfile read data, same cycle.
- ex_wreg_i, ex_wd_i, ex_wdata_i  in  1/REG_AW/DATA_W  EX-stage write-back candidate.
- mem_wreg_i, mem_wd_i, mem_wdata_i  in  1/REG_AW/DATA_W  MEM-stage write-back candidate.
- out_valid_o  out  1  the ID/EX register holds an instruction.
- ex_ready_i  in  1  EX consumes the ID/EX register this cycle.
- pc_o  out  32  registered pc.
- aluop_o  out  8  registered ALU subtype.
- alusel_o  out  3  registered ALU class.
- reg1_o / reg2_o  out  DATA_W  registered source operands.
- wd_o  out  REG_AW  registered destination register.
- wreg_o  out  1  registered write enable.
- is_load_o  out  1  registered flag: the instruction is LW.
- inst_invalid_o  out  1  registered flag: the opcode is undecoded.
- invalid_cnt_o  out  CNT_W  saturating count of accepted invalid instructions.

## Operation
- **Decode** (zero extension is to DATA_W unless stated):
  - ORI 001101 / ANDI 001100 / XORI 001110: aluop 00100101 / 00100100 / 00100110, alusel 001. Reads rs only. imm = zero-extended inst[15:0]. wd = rt, wreg = 1.
  - LUI 001111: aluop 00100101, alusel 001. Reads rs with the address forced to 0. imm = inst[15:0]<<16. wd = rt, wreg = 1.
  - SPECIAL 000000 with shamt = 0 and funct AND 100100 / OR 100101 / XOR 100110 / NOR 100111: aluop = {2'b00, funct}, alusel 001. Reads rs and rt. wd = rd, wreg = 1.
  - LW 100011: aluop 11100011, alusel 111. Reads rs. imm = sign-extended inst[15:0]. wd = rt, wreg = 1, is_load = 1.
  - Anything else: aluop 0, alusel 0, wreg 0, no reads, inst_invalid = 1.
- **Operand select** (per port):
  - If the port's read enable is 0, the operand is imm for port 2 and 0 for port 1.
  - Otherwise, in priority order:
    - Address 0 gives 0.
    - If ex_wreg_i and ex_wd_i match, use ex_wdata_i.
    - Else if mem_wreg_i and mem_wd_i match, use mem_wdata_i.
    - Else use the regfile data.
- **Load-use stall**: the stall condition is true when all of the following hold:
  - out_valid_o, is_load_o and wreg_o are 1.
  - wd_o ≠ 0.
  - wd_o equals an address that the current instruction reads with its read enable set.
- **Advance**: advance = ~out_valid_o | ex_ready_i.
- **Ready**: in_ready_o = flush_i | (advance & ~stall).
- **ID/EX register update** on each edge, first match wins:
  - flush_i: out_valid ← 0; the input is consumed and dropped.
  - ~advance: hold all outputs.
  - stall: out_valid ← 0 (bubble).
  - in_valid_i: load the decoded fields, out_valid ← 1.
  - Otherwise: out_valid ← 0.
- **Invalid count**: invalid_cnt increments when an invalid instruction is loaded into ID/EX. It saturates at all-ones.

## Timing
- Reset values: every registered output and invalid_cnt_o are 0, out_valid_o = 0.
- Combinational outputs during reset follow inst_i, but in_ready_o is 0.
- Latency: an instruction accepted at edge N appears on the outputs immediately after edge N, i.e. one cycle.
- Forwarding uses the EX/MEM inputs sampled in the acceptance cycle.
- Backpressure: while out_valid_o & ~ex_ready_i, all outputs are stable and in_ready_o = 0 (unless flush_i).
- A load-use stall inserts exactly one bubble. In the next cycle the load has left ID/EX, so the condition clears and the dependent instruction is accepted, forwarding from MEM.
- flush_i has priority over stall, hold and accept in the same cycle.
- Reset asserted mid-operation clears out_valid_o asynchronously. The in-flight instruction is lost and is not counted.

## Test plan
- **ORI with forwarding**: reset, then ORI inst 0x34220F0F, with $1 = 0x1 in the regfile and ex_wd = 1, ex_wdata = 0x100. Required next cycle: reg1_o = 0x100, reg2_o = 0x0F0F, wd_o = 2, aluop 0x25, out_valid 1.
- **Forwarding priority**: OR $3,$1,$2 (0x00221825), with EX and MEM both targeting $1 (0xA, 0xB) and MEM targeting $2 (0xC). Required: reg1_o = 0xA, reg2_o = 0xC. Repeat targeting $0: operand 0.
- **Load-use**: LW $4,4($0) followed by ANDI $5,$4,0xFF, with ex_ready held 1. Required:
  - Cycle 2: in_ready_o = 0, then out_valid 0 for one cycle.
  - The ANDI then issues with reg1_o = mem_wdata_i.
- **Backpressure**: ex_ready_i = 0 for 3 cycles with valid output. Required: all outputs unchanged and in_ready_o = 0, then the next instruction is accepted on release.
- **Flush versus stall**: assert flush_i together with the load-use condition. Required: out_valid_o = 0 next cycle, in_ready_o = 1, the instruction is dropped, and invalid_cnt is unchanged.
- **Invalid opcodes and async reset**: feed inst 0xFC000000 three times. Required: inst_invalid_o = 1, wreg_o = 0, invalid_cnt_o = 3. Pulse rst low mid-cycle: outputs clear to 0 immediately. With CNT_W = 2, the counter saturates at 3.
